// File: rtl/time_keeper_pkg.sv
// ============================================================================
// Module   : time_pkg
// Brief    : Shared digit widths, FSM states, limits and BCD legality check
//            for the wall-clock time keeper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package time_pkg;

  localparam int HT_W = 2;
  localparam int HO_W = 4;
  localparam int MT_W = 3;
  localparam int MO_W = 4;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    CHECK = 1'b1
  } state_e;

  localparam logic [MT_W-1:0] MAX_MIN_TENS = 3'd5;
  localparam logic [HO_W-1:0] MAX_ONES     = 4'd9;
  localparam logic [5:0]      MAX_HOUR_24  = 6'd23;
  localparam logic [5:0]      MAX_HOUR_12  = 6'd12;

  // Once the ones digit is known to be decimal, ht*10+ho is the binary hour.
  function automatic logic bcd_legal(
    input logic [HT_W-1:0] ht,
    input logic [HO_W-1:0] ho,
    input logic [MT_W-1:0] mt,
    input logic [MO_W-1:0] mo,
    input logic            twelve
  );
    logic [5:0] hours;
    logic       ok;
    hours = 6'(ht) * 6'd10 + 6'(ho);
    ok    = (ho <= MAX_ONES) && (mo <= MAX_ONES) && (mt <= MAX_MIN_TENS);
    if (twelve) begin
      ok = ok && (hours != 6'd0) && (hours <= MAX_HOUR_12);
    end else begin
      ok = ok && (hours <= MAX_HOUR_24);
    end
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/time_keeper_pulse_sync.sv
// ============================================================================
// Module   : pulse_sync
// Brief    : Multi-flop synchroniser followed by a rising-edge detector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk256,
  input  logic reset,
  input  logic async_in,
  output logic tick
);

  logic [SYNC_STAGES-1:0] sync_d, sync_q;
  logic                   edge_d, edge_q;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    edge_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk256 or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      edge_q <= edge_d;
    end
  end

  assign tick = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

`default_nettype wire

// File: rtl/time_keeper.sv
// ============================================================================
// Module   : time_keeper
// Brief    : BCD HH:MM wall clock advanced by the one_minute strobe, with a
//            validated valid/ack/err time-set load. Define TWELVE_HOUR_EN for
//            12-hour display with pm flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module time_keeper
  import time_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int RESET_HOURS   = 0,
  parameter int RESET_MINUTES = 0
) (
  input  logic            clk256,
  input  logic            reset,
  input  logic            one_minute,
  input  logic            load_valid,
  input  logic [HT_W-1:0] load_hh_t,
  input  logic [HO_W-1:0] load_hh_o,
  input  logic [MT_W-1:0] load_mm_t,
  input  logic [MO_W-1:0] load_mm_o,
`ifdef TWELVE_HOUR_EN
  input  logic            load_pm,
  output logic            pm,
`endif
  output logic            load_ack,
  output logic            load_err,
  output logic [HT_W-1:0] hh_t,
  output logic [HO_W-1:0] hh_o,
  output logic [MT_W-1:0] mm_t,
  output logic [MO_W-1:0] mm_o,
  output logic            minute_tick,
  output logic            day_tick
);

`ifdef TWELVE_HOUR_EN
  localparam logic TWELVE = 1'b1;
  localparam int   RST_H  = (RESET_HOURS % 12 == 0) ? 12 : (RESET_HOURS % 12);
  localparam logic RST_PM = (RESET_HOURS >= 12);
`else
  localparam logic TWELVE = 1'b0;
  localparam int   RST_H  = RESET_HOURS;
`endif
  localparam logic [HT_W-1:0] RST_HT = HT_W'(RST_H / 10);
  localparam logic [HO_W-1:0] RST_HO = HO_W'(RST_H % 10);
  localparam logic [MT_W-1:0] RST_MT = MT_W'(RESET_MINUTES / 10);
  localparam logic [MO_W-1:0] RST_MO = MO_W'(RESET_MINUTES % 10);

  logic tick;

  state_e          state_d, state_q;
  logic [HT_W-1:0] hh_t_d, hh_t_q, hold_hh_t_d, hold_hh_t_q, inc_hh_t;
  logic [HO_W-1:0] hh_o_d, hh_o_q, hold_hh_o_d, hold_hh_o_q, inc_hh_o;
  logic [MT_W-1:0] mm_t_d, mm_t_q, hold_mm_t_d, hold_mm_t_q, inc_mm_t;
  logic [MO_W-1:0] mm_o_d, mm_o_q, hold_mm_o_d, hold_mm_o_q, inc_mm_o;
  logic            inc_day;
  logic            pend_d, pend_q;
  logic            minute_tick_d, minute_tick_q;
  logic            day_tick_d, day_tick_q;
  logic            load_ack_d, load_ack_q;
  logic            load_err_d, load_err_q;
`ifdef TWELVE_HOUR_EN
  logic            pm_d, pm_q, hold_pm_d, hold_pm_q, inc_pm;
`endif

  pulse_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk256   (clk256),
    .reset    (reset),
    .async_in (one_minute),
    .tick     (tick)
  );

  // Next-minute value, computed digit by digit so every carry stays in BCD.
  always_comb begin
    inc_mm_o = mm_o_q + 4'd1;
    inc_mm_t = mm_t_q;
    inc_hh_o = hh_o_q;
    inc_hh_t = hh_t_q;
    inc_day  = 1'b0;
`ifdef TWELVE_HOUR_EN
    inc_pm   = pm_q;
`endif
    if (mm_o_q == MAX_ONES) begin
      inc_mm_o = 4'd0;
      inc_mm_t = mm_t_q + 3'd1;
      if (mm_t_q == MAX_MIN_TENS) begin
        inc_mm_t = 3'd0;
        inc_hh_o = hh_o_q + 4'd1;
`ifdef TWELVE_HOUR_EN
        if (hh_t_q == 2'd1 && hh_o_q == 4'd2) begin
          inc_hh_t = 2'd0;
          inc_hh_o = 4'd1;
        end else if (hh_t_q == 2'd1 && hh_o_q == 4'd1) begin
          inc_pm  = ~pm_q;
          inc_day = pm_q;
        end else if (hh_o_q == MAX_ONES) begin
          inc_hh_t = hh_t_q + 2'd1;
          inc_hh_o = 4'd0;
        end
`else
        if (hh_t_q == 2'd2 && hh_o_q == 4'd3) begin
          inc_hh_t = 2'd0;
          inc_hh_o = 4'd0;
          inc_day  = 1'b1;
        end else if (hh_o_q == MAX_ONES) begin
          inc_hh_t = hh_t_q + 2'd1;
          inc_hh_o = 4'd0;
        end
`endif
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    hh_t_d        = hh_t_q;
    hh_o_d        = hh_o_q;
    mm_t_d        = mm_t_q;
    mm_o_d        = mm_o_q;
    hold_hh_t_d   = hold_hh_t_q;
    hold_hh_o_d   = hold_hh_o_q;
    hold_mm_t_d   = hold_mm_t_q;
    hold_mm_o_d   = hold_mm_o_q;
    pend_d        = pend_q;
    minute_tick_d = 1'b0;
    day_tick_d    = 1'b0;
    load_ack_d    = 1'b0;
    load_err_d    = 1'b0;
`ifdef TWELVE_HOUR_EN
    pm_d          = pm_q;
    hold_pm_d     = hold_pm_q;
`endif
    case (state_q)
      RUN: begin
        if (tick || pend_q) begin
          hh_t_d        = inc_hh_t;
          hh_o_d        = inc_hh_o;
          mm_t_d        = inc_mm_t;
          mm_o_d        = inc_mm_o;
          minute_tick_d = 1'b1;
          day_tick_d    = inc_day;
          pend_d        = 1'b0;
`ifdef TWELVE_HOUR_EN
          pm_d          = inc_pm;
`endif
        end
        if (load_valid) begin
          hold_hh_t_d = load_hh_t;
          hold_hh_o_d = load_hh_o;
          hold_mm_t_d = load_mm_t;
          hold_mm_o_d = load_mm_o;
`ifdef TWELVE_HOUR_EN
          hold_pm_d   = load_pm;
`endif
          state_d     = CHECK;
        end
      end
      CHECK: begin
        state_d = RUN;
        if (bcd_legal(hold_hh_t_q, hold_hh_o_q, hold_mm_t_q, hold_mm_o_q, TWELVE)) begin
          hh_t_d     = hold_hh_t_q;
          hh_o_d     = hold_hh_o_q;
          mm_t_d     = hold_mm_t_q;
          mm_o_d     = hold_mm_o_q;
`ifdef TWELVE_HOUR_EN
          pm_d       = hold_pm_q;
`endif
          load_ack_d = 1'b1;
          pend_d     = 1'b0;
        end else begin
          // Keep the minute that arrived while checking; RUN applies it next.
          load_err_d = 1'b1;
          pend_d     = pend_q | tick;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk256 or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      hh_t_q        <= RST_HT;
      hh_o_q        <= RST_HO;
      mm_t_q        <= RST_MT;
      mm_o_q        <= RST_MO;
      hold_hh_t_q   <= '0;
      hold_hh_o_q   <= '0;
      hold_mm_t_q   <= '0;
      hold_mm_o_q   <= '0;
      pend_q        <= 1'b0;
      minute_tick_q <= 1'b0;
      day_tick_q    <= 1'b0;
      load_ack_q    <= 1'b0;
      load_err_q    <= 1'b0;
`ifdef TWELVE_HOUR_EN
      pm_q          <= RST_PM;
      hold_pm_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      hh_t_q        <= hh_t_d;
      hh_o_q        <= hh_o_d;
      mm_t_q        <= mm_t_d;
      mm_o_q        <= mm_o_d;
      hold_hh_t_q   <= hold_hh_t_d;
      hold_hh_o_q   <= hold_hh_o_d;
      hold_mm_t_q   <= hold_mm_t_d;
      hold_mm_o_q   <= hold_mm_o_d;
      pend_q        <= pend_d;
      minute_tick_q <= minute_tick_d;
      day_tick_q    <= day_tick_d;
      load_ack_q    <= load_ack_d;
      load_err_q    <= load_err_d;
`ifdef TWELVE_HOUR_EN
      pm_q          <= pm_d;
      hold_pm_q     <= hold_pm_d;
`endif
    end
  end

  assign hh_t        = hh_t_q;
  assign hh_o        = hh_o_q;
  assign mm_t        = mm_t_q;
  assign mm_o        = mm_o_q;
  assign minute_tick = minute_tick_q;
  assign day_tick    = day_tick_q;
  assign load_ack    = load_ack_q;
  assign load_err    = load_err_q;
`ifdef TWELVE_HOUR_EN
  assign pm          = pm_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_time_keeper.sv
// ============================================================================
// Module   : tb_time_keeper
// Brief    : Directed self-checking bench for time_keeper (24-hour default,
//            12-hour sections when TWELVE_HOUR_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_time_keeper;

  logic       clk256 = 1'b0;
  logic       reset;
  logic       one_minute;
  logic       load_valid;
  logic [1:0] load_hh_t;
  logic [3:0] load_hh_o;
  logic [2:0] load_mm_t;
  logic [3:0] load_mm_o;
  logic       load_ack, load_err, minute_tick, day_tick;
  logic [1:0] hh_t;
  logic [3:0] hh_o;
  logic [2:0] mm_t;
  logic [3:0] mm_o;
`ifdef TWELVE_HOUR_EN
  logic       load_pm, pm;
  localparam logic [15:0] RST_TIME = 16'h1200;
`else
  localparam logic [15:0] RST_TIME = 16'h0000;
`endif

  int          tests = 0;
  int          fails = 0;
  int          st_cnt, st_at, st_dcnt, st_dat;
  int          tick_total;
  logic [15:0] exp_time;

  always #5 clk256 = ~clk256;

  time_keeper dut (
    .clk256      (clk256),
    .reset       (reset),
    .one_minute  (one_minute),
    .load_valid  (load_valid),
    .load_hh_t   (load_hh_t),
    .load_hh_o   (load_hh_o),
    .load_mm_t   (load_mm_t),
    .load_mm_o   (load_mm_o),
`ifdef TWELVE_HOUR_EN
    .load_pm     (load_pm),
    .pm          (pm),
`endif
    .load_ack    (load_ack),
    .load_err    (load_err),
    .hh_t        (hh_t),
    .hh_o        (hh_o),
    .mm_t        (mm_t),
    .mm_o        (mm_o),
    .minute_tick (minute_tick),
    .day_tick    (day_tick)
  );

  function automatic logic [15:0] now();
    return {2'b00, hh_t, hh_o, 1'b0, mm_t, mm_o};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk256);
    @(negedge clk256);
  endtask

  // One strobe: high for hi edges, low for lo edges; records tick positions.
  task automatic strobe(input int hi, input int lo);
    st_cnt = 0; st_at = 0; st_dcnt = 0; st_dat = 0;
    one_minute = 1'b1;
    for (int c = 1; c <= hi + lo; c++) begin
      cyc();
      if (c == hi) one_minute = 1'b0;
      if (minute_tick) begin st_cnt++; st_at = c; end
      if (day_tick) begin st_dcnt++; st_dat = c; end
    end
    tick_total += st_cnt;
  endtask

  task automatic drive_load(input logic [1:0] ht, input logic [3:0] ho,
                            input logic [2:0] mt, input logic [3:0] mo, input logic pmv);
    load_valid = 1'b1;
    load_hh_t  = ht;
    load_hh_o  = ho;
    load_mm_t  = mt;
    load_mm_o  = mo;
`ifdef TWELVE_HOUR_EN
    load_pm    = pmv;
`else
    if (pmv) load_hh_t = ht;
`endif
  endtask

  task automatic do_load(input logic [1:0] ht, input logic [3:0] ho, input logic [2:0] mt,
                         input logic [3:0] mo, input logic pmv, input logic exp_ack,
                         input string tag);
    drive_load(ht, ho, mt, mo, pmv);
    cyc();
    load_valid = 1'b0;
    chk({tag, " in_check"}, {30'd0, load_ack, load_err}, 32'd0);
    cyc();
    chk({tag, " ack_err"}, {30'd0, load_ack, load_err}, {30'd0, exp_ack, ~exp_ack});
    cyc();
    chk({tag, " pulse_end"}, {30'd0, load_ack, load_err}, 32'd0);
  endtask

  // Strobe timed so its tick is seen while the FSM sits in CHECK.
  task automatic load_with_tick(input logic [1:0] ht, input logic [3:0] ho, input logic [2:0] mt,
                                input logic [3:0] mo, input logic exp_ack,
                                input logic [15:0] t_leave, input logic [15:0] t_after,
                                input logic mt_after, input string tag);
    one_minute = 1'b1;
    cyc();
    drive_load(ht, ho, mt, mo, 1'b0);
    cyc();
    load_valid = 1'b0;
    chk({tag, " tick_in_check"}, {31'd0, minute_tick}, 32'd0);
    cyc();
    chk({tag, " ack_err"}, {30'd0, load_ack, load_err}, {30'd0, exp_ack, ~exp_ack});
    chk({tag, " time_leave"}, {16'd0, now()}, {16'd0, t_leave});
    chk({tag, " tick_leave"}, {31'd0, minute_tick}, 32'd0);
    cyc();
    chk({tag, " time_after"}, {16'd0, now()}, {16'd0, t_after});
    chk({tag, " tick_after"}, {31'd0, minute_tick}, {31'd0, mt_after});
    repeat (20) cyc();
    one_minute = 1'b0;
    repeat (6) cyc();
    chk({tag, " time_end"}, {16'd0, now()}, {16'd0, t_after});
  endtask

  initial begin
    reset = 1'b1; one_minute = 1'b0; load_valid = 1'b0;
    load_hh_t = '0; load_hh_o = '0; load_mm_t = '0; load_mm_o = '0;
`ifdef TWELVE_HOUR_EN
    load_pm = 1'b0;
`endif
    tick_total = 0;
    repeat (3) cyc();
    chk("reset time", {16'd0, now()}, {16'd0, RST_TIME});
    chk("reset pulses", {28'd0, load_ack, load_err, minute_tick, day_tick}, 32'd0);
`ifdef TWELVE_HOUR_EN
    chk("reset pm", {31'd0, pm}, 32'd0);
`endif
    reset = 1'b0;
    cyc();

    // 60 one-second strobes: one hour, each tick 3 edges after the rise
    for (int i = 0; i < 60; i++) begin
      strobe(256, 4);
      chk("strobe latency", st_at, 3);
      chk("strobe count", st_cnt, 1);
    end
    chk("hour ticks", tick_total, 60);
    chk("after 60 min", {16'd0, now()}, 32'h0100);

`ifndef TWELVE_HOUR_EN
    do_load(2'd2, 4'd3, 3'd5, 4'd8, 1'b0, 1'b1, "load 2358");
    chk("time 2358", {16'd0, now()}, 32'h2358);
    strobe(256, 4);
    chk("time 2359", {16'd0, now()}, 32'h2359);
    chk("no day 2359", st_dcnt, 0);
    strobe(256, 4);
    chk("time 0000", {16'd0, now()}, 32'h0000);
    chk("day count", st_dcnt, 1);
    chk("day with minute", st_dat, st_at);
    chk("day latency", st_dat, 3);
    exp_time = 16'h0000;
`else
    exp_time = 16'h0100;
`endif

    do_load(2'd2, 4'd4, 3'd0, 4'd0, 1'b0, 1'b0, "illegal 2400");
    chk("time after 2400", {16'd0, now()}, {16'd0, exp_time});
    do_load(2'd1, 4'd2, 3'd6, 4'd0, 1'b0, 1'b0, "illegal 1260");
    chk("time after 1260", {16'd0, now()}, {16'd0, exp_time});
    do_load(2'd1, 4'hA, 3'd0, 4'd0, 1'b0, 1'b0, "illegal 1A00");
    chk("time after 1A00", {16'd0, now()}, {16'd0, exp_time});

    load_with_tick(2'd1, 4'd0, 3'd1, 4'd5, 1'b1, 16'h1015, 16'h1015, 1'b0, "legal 1015");
    do_load(2'd1, 4'd0, 3'd1, 4'd4, 1'b0, 1'b1, "load 1014");
    chk("time 1014", {16'd0, now()}, 32'h1014);
    load_with_tick(2'd2, 4'd4, 3'd0, 4'd0, 1'b0, 16'h1014, 16'h1015, 1'b1, "rej 2400");

    // Fast mode: 1 Hz square wave, 0.5 s high
    tick_total = 0;
    repeat (5) strobe(128, 128);
    chk("fast ticks", tick_total, 5);
    chk("fast time", {16'd0, now()}, 32'h1020);

    drive_load(2'd1, 4'd2, 3'd3, 4'd4, 1'b0);
    cyc();
    load_valid = 1'b0;
    #1 reset = 1'b1;
    #1 chk("abort time", {16'd0, now()}, {16'd0, RST_TIME});
    cyc();
    chk("abort pulses a", {30'd0, load_ack, load_err}, 32'd0);
    reset = 1'b0;
    cyc();
    chk("abort pulses b", {30'd0, load_ack, load_err}, 32'd0);
    cyc();
    chk("abort pulses c", {30'd0, load_ack, load_err}, 32'd0);
    chk("abort time end", {16'd0, now()}, {16'd0, RST_TIME});

`ifdef TWELVE_HOUR_EN
    do_load(2'd1, 4'd1, 3'd5, 4'd9, 1'b1, 1'b1, "load 1159pm");
    chk("pm set", {31'd0, pm}, 32'd1);
    strobe(256, 4);
    chk("midnight time", {16'd0, now()}, 32'h1200);
    chk("midnight pm", {31'd0, pm}, 32'd0);
    chk("midnight day", st_dcnt, 1);
    chk("midnight day pos", st_dat, 3);
    do_load(2'd0, 4'd0, 3'd3, 4'd0, 1'b0, 1'b0, "illegal 0030");
    chk("time after 0030", {16'd0, now()}, 32'h1200);
    do_load(2'd1, 4'd2, 3'd5, 4'd9, 1'b0, 1'b1, "load 1259");
    strobe(256, 4);
    chk("12 to 1 time", {16'd0, now()}, 32'h0100);
    chk("12 to 1 pm", {31'd0, pm}, 32'd0);
    chk("12 to 1 day", st_dcnt, 0);
    do_load(2'd1, 4'd1, 3'd5, 4'd9, 1'b0, 1'b1, "load 1159am");
    strobe(256, 4);
    chk("noon time", {16'd0, now()}, 32'h1200);
    chk("noon pm", {31'd0, pm}, 32'd1);
    chk("noon day", st_dcnt, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
